dht11_ascii_framer: RTL

//  Downstream of the DHT11 interface. Captures each completed 32-bit measurement and

---
 rtl/dht11_ascii_framer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dht11_ascii_framer.sv
// dht11_ascii_framer: captures a completed 32-bit DHT11 measurement, converts each byte to
// three decimal digits (serial double-dabble) and streams a fixed ASCII line over a
// valid/ready byte port. Optional build macro DHT_FRAMER_SEQNUM_EN prefixes each line with
// "#HH " carrying an 8-bit wrapping frame sequence number.
module dht11_ascii_framer #(
    parameter logic [7:0] H_TAG    = 8'h48,
    parameter logic [7:0] T_TAG    = 8'h54,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [31:0] sensor_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        frame_drop_o
);

`ifdef DHT_FRAMER_SEQNUM_EN
    localparam logic [4:0] Pre = 5'd4;
`else
    localparam logic [4:0] Pre = 5'd0;
`endif
    localparam logic [4:0] LastIdx = Pre + 5'd20;

    typedef enum logic [1:0] {StIdle, StConvert, StEmit, StDone} state_e;

    state_e            state_q;
    logic              dv_q;
    logic [31:0]       shadow_q;
    logic [31:0]       pend_word_q;
    logic              pending_q;
    logic [4:0]        cnt_q;
    logic [4:0]        idx_q;
    logic [11:0]       work_q;
    logic [3:0][11:0]  bcd_q;
`ifdef DHT_FRAMER_SEQNUM_EN
    logic [7:0]        seq_q;
`endif

    logic        trig;
    logic [11:0] adj;
    logic [11:0] work_next;
    logic [4:0]  char_idx;
    logic [4:0]  pos;
    logic [7:0]  next_char;

    function automatic logic [7:0] dig(input logic [3:0] d);
        return {4'h3, d};
    endfunction

`ifdef DHT_FRAMER_SEQNUM_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    // Rising edge of data_valid; dv_q resets high so a level present at reset is ignored.
    assign trig = data_valid_i & ~dv_q;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next data bit.
    always_comb begin
        adj = work_q;
        for (int k = 0; k < 3; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
        end
        work_next = (adj << 1) | {11'b0, shadow_q[31]};
    end

    // Character generator for the byte that will be loaded into tx_data next.
    always_comb begin
        char_idx  = (state_q == StEmit) ? idx_q + 5'd1 : 5'd0;
        pos       = char_idx - Pre;
        next_char = 8'h00;
        unique case (pos)
            5'd0:  next_char = H_TAG;
            5'd1:  next_char = 8'h3D;
            5'd2:  next_char = dig(bcd_q[0][11:8]);
            5'd3:  next_char = dig(bcd_q[0][7:4]);
            5'd4:  next_char = dig(bcd_q[0][3:0]);
            5'd5:  next_char = 8'h2E;
            5'd6:  next_char = dig(bcd_q[1][11:8]);
            5'd7:  next_char = dig(bcd_q[1][7:4]);
            5'd8:  next_char = dig(bcd_q[1][3:0]);
            5'd9:  next_char = SEP_CHAR;
            5'd10: next_char = T_TAG;
            5'd11: next_char = 8'h3D;
            5'd12: next_char = dig(bcd_q[2][11:8]);
            5'd13: next_char = dig(bcd_q[2][7:4]);
            5'd14: next_char = dig(bcd_q[2][3:0]);
            5'd15: next_char = 8'h2E;
            5'd16: next_char = dig(bcd_q[3][11:8]);
            5'd17: next_char = dig(bcd_q[3][7:4]);
            5'd18: next_char = dig(bcd_q[3][3:0]);
            5'd19: next_char = 8'h0D;
            5'd20: next_char = 8'h0A;
            default: next_char = 8'h00;
        endcase
`ifdef DHT_FRAMER_SEQNUM_EN
        if (char_idx < Pre) begin
            unique case (char_idx[1:0])
                2'd0: next_char = 8'h23;
                2'd1: next_char = hex_char(seq_q[7:4]);
                2'd2: next_char = hex_char(seq_q[3:0]);
                2'd3: next_char = 8'h20;
                default: next_char = 8'h00;
            endcase
        end
`endif
    end

    // Frame FSM with registered outputs, pending-word buffer and drop detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            dv_q         <= 1'b1;
            shadow_q     <= '0;
            pend_word_q  <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            work_q       <= '0;
            bcd_q        <= '0;
            tx_data_o    <= '0;
            tx_valid_o   <= 1'b0;
            busy_o       <= 1'b0;
            frame_drop_o <= 1'b0;
`ifdef DHT_FRAMER_SEQNUM_EN
            seq_q        <= '0;
`endif
        end else begin
            dv_q         <= data_valid_i;
            frame_drop_o <= 1'b0;

            // DONE handles its own trigger so it can hand a pending word straight on.
            if (trig && state_q != StIdle && state_q != StDone) begin
                pend_word_q <= sensor_data_i;
                pending_q   <= 1'b1;
                if (pending_q) frame_drop_o <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        shadow_q <= sensor_data_i;
                        busy_o   <= 1'b1;
                        cnt_q    <= '0;
                        work_q   <= '0;
                        state_q  <= StConvert;
                    end
                end
                StConvert: begin
                    shadow_q <= {shadow_q[30:0], 1'b0};
                    work_q   <= work_next;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q[2:0] == 3'd7) begin
                        bcd_q[cnt_q[4:3]] <= work_next;
                        work_q            <= '0;
                    end
                    if (cnt_q == 5'd31) begin
                        idx_q      <= '0;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= next_char;
                        state_q    <= StEmit;
                    end
                end
                StEmit: begin
                    if (tx_ready_i) begin
                        if (idx_q == LastIdx) begin
                            tx_valid_o <= 1'b0;
                            state_q    <= StDone;
                        end else begin
                            idx_q     <= idx_q + 5'd1;
                            tx_data_o <= next_char;
                        end
                    end
                end
                StDone: begin
`ifdef DHT_FRAMER_SEQNUM_EN
                    seq_q <= seq_q + 8'd1;
`endif
                    cnt_q  <= '0;
                    work_q <= '0;
                    if (pending_q) begin
                        shadow_q  <= pend_word_q;
                        pending_q <= trig;
                        if (trig) pend_word_q <= sensor_data_i;
                        state_q   <= StConvert;
                    end else if (trig) begin
                        shadow_q <= sensor_data_i;
                        state_q  <= StConvert;
                    end else begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
